// File: rtl/eth_rst_pkg.sv
// Shared types and constants for the Ethernet reset sequencer.
// Holds the sequencer states, the output bundle and its per-state decode.
package eth_rst_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_PHY_RST   = 3'd1,
    ST_PHY_WAIT  = 3'd2,
    ST_CORE_DLY  = 3'd3,
    ST_RUN       = 3'd4
  } eth_rst_st_t;

  localparam int RELOCK_CNT_W = 8;
  localparam logic [RELOCK_CNT_W-1:0] RELOCK_CNT_MAX = 8'hFF;
  localparam logic [RELOCK_CNT_W-1:0] RELOCK_CNT_ONE = 8'h01;
  localparam logic [RELOCK_CNT_W-1:0] RELOCK_CNT_ZERO = 8'h00;

  typedef struct packed {
    logic phy_rst_n;
    logic mac_rst;
    logic core_rst;
    logic rst_done;
  } rst_out_t;

  localparam rst_out_t RST_OUT_INIT = '{phy_rst_n: 1'b0, mac_rst: 1'b1, core_rst: 1'b1, rst_done: 1'b0};

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    else m = m;
    if (c > m) m = c;
    else m = m;
    if (d > m) m = d;
    else m = m;
    return m;
  endfunction

  // Resets release cumulatively: PHY first, then MAC, then core.
  function automatic rst_out_t decode_outputs(input eth_rst_st_t st);
    rst_out_t o;
    o = RST_OUT_INIT;
    case (st)
      ST_WAIT_LOCK: o = RST_OUT_INIT;
      ST_PHY_RST:   o = RST_OUT_INIT;
      ST_PHY_WAIT:  o = '{phy_rst_n: 1'b1, mac_rst: 1'b1, core_rst: 1'b1, rst_done: 1'b0};
      ST_CORE_DLY:  o = '{phy_rst_n: 1'b1, mac_rst: 1'b0, core_rst: 1'b1, rst_done: 1'b0};
      ST_RUN:       o = '{phy_rst_n: 1'b1, mac_rst: 1'b0, core_rst: 1'b0, rst_done: 1'b1};
      default:      o = RST_OUT_INIT;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/eth_rst_seq_if.sv
// Lock input and reset outputs of the Ethernet reset sequencer.
// The sequencer is the master; whatever consumes the resets is the slave.
interface eth_rst_seq_if;
  import eth_rst_pkg::*;

  logic                    clk_locked;
  logic                    phy_rst_n;
  logic                    mac_rst;
  logic                    core_rst;
  logic                    rst_done;
  logic [RELOCK_CNT_W-1:0] relock_cnt;

  modport master (
    input  clk_locked,
    output phy_rst_n,
    output mac_rst,
    output core_rst,
    output rst_done,
    output relock_cnt
  );

  modport slave (
    output clk_locked,
    input  phy_rst_n,
    input  mac_rst,
    input  core_rst,
    input  rst_done,
    input  relock_cnt
  );
endinterface

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Reset clears every stage so the output starts low.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_r;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/eth_rst_seq.sv
// Ordered Ethernet reset sequencer: PHY reset pulse, MAC release, core release,
// restarted on any loss of MMCM lock, with a saturating relock event counter.
module eth_rst_seq
  import eth_rst_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int PHY_RST_CYCLES     = 1250000,
  parameter int PHY_WAIT_CYCLES    = 625000,
  parameter int CORE_DLY_CYCLES    = 16
) (
  input  logic          clk_in,
  input  logic          rst_in,
  eth_rst_seq_if.master rst_if
);

  localparam int MAX_CYC = max_of4(LOCK_STABLE_CYCLES, PHY_RST_CYCLES, PHY_WAIT_CYCLES, CORE_DLY_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  // Loads are count-1 so that expiry is detected on the last cycle of each state.
  localparam logic [CNT_W-1:0] LOCK_LOAD     = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHY_RST_LOAD  = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHY_WAIT_LOAD = CNT_W'(PHY_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_DLY_LOAD = CNT_W'(CORE_DLY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO      = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                    lock_s;
  logic                    lock_loss_s;
  logic                    cnt_done_s;
  eth_rst_st_t             state_r;
  eth_rst_st_t             state_nxt_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        cnt_nxt_s;
  rst_out_t                out_r;
  rst_out_t                out_nxt_s;
  logic [RELOCK_CNT_W-1:0] relock_cnt_r;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk_in),
    .rst (rst_in),
    .d   (rst_if.clk_locked),
    .q   (lock_s)
  );

  assign lock_loss_s = (state_r != ST_WAIT_LOCK) && !lock_s;
  assign cnt_done_s  = (cnt_r == CNT_ZERO);

  // Next-state and shared down-counter; lock loss outranks counter expiry.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (lock_loss_s) begin
      state_nxt_s = ST_WAIT_LOCK;
      cnt_nxt_s   = LOCK_LOAD;
    end else begin
      case (state_r)
        ST_WAIT_LOCK: begin
          if (!lock_s) begin
            cnt_nxt_s = LOCK_LOAD;
          end else if (cnt_done_s) begin
            state_nxt_s = ST_PHY_RST;
            cnt_nxt_s   = PHY_RST_LOAD;
          end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end
        end
        ST_PHY_RST: begin
          if (cnt_done_s) begin
            state_nxt_s = ST_PHY_WAIT;
            cnt_nxt_s   = PHY_WAIT_LOAD;
          end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end
        end
        ST_PHY_WAIT: begin
          if (cnt_done_s) begin
            state_nxt_s = ST_CORE_DLY;
            cnt_nxt_s   = CORE_DLY_LOAD;
          end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end
        end
        ST_CORE_DLY: begin
          if (cnt_done_s) begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end
        end
        ST_RUN: begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = cnt_r;
        end
        default: begin
          state_nxt_s = ST_WAIT_LOCK;
          cnt_nxt_s   = LOCK_LOAD;
        end
      endcase
    end
  end

  assign out_nxt_s = decode_outputs(state_nxt_s);

  // State, counter and outputs update together so outputs track state on the same edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r <= ST_WAIT_LOCK;
      cnt_r   <= CNT_ZERO;
      out_r   <= RST_OUT_INIT;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      out_r   <= out_nxt_s;
    end
  end

  // Relock events saturate rather than wrap so a flapping clock stays visible.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      relock_cnt_r <= RELOCK_CNT_ZERO;
    end else if (lock_loss_s && (relock_cnt_r != RELOCK_CNT_MAX)) begin
      relock_cnt_r <= relock_cnt_r + RELOCK_CNT_ONE;
    end else begin
      relock_cnt_r <= relock_cnt_r;
    end
  end

  assign rst_if.phy_rst_n  = out_r.phy_rst_n;
  assign rst_if.mac_rst    = out_r.mac_rst;
  assign rst_if.core_rst   = out_r.core_rst;
  assign rst_if.rst_done   = out_r.rst_done;
  assign rst_if.relock_cnt = relock_cnt_r;

endmodule

// File: tb/tb_eth_rst_seq.sv
// Self-checking bench for eth_rst_seq: the expected outputs follow from the length of
// the current unbroken run of synchronized lock, plus literal timing pins.
module tb_eth_rst_seq;
  localparam int SS = 2;
  localparam int LS = 8;
  localparam int PR = 20;
  localparam int PW = 10;
  localparam int CD = 4;

  logic clk_in = 1'b0;
  logic rst_in;

  eth_rst_seq_if rif ();

  eth_rst_seq #(
    .SYNC_STAGES        (SS),
    .LOCK_STABLE_CYCLES (LS),
    .PHY_RST_CYCLES     (PR),
    .PHY_WAIT_CYCLES    (PW),
    .CORE_DLY_CYCLES    (CD)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rst_if (rif)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Model: the lock seen by the sequencer is clk_locked delayed SS edges; outputs are
  // a function of how many consecutive high samples it has seen.
  bit lk_pipe[$];
  int run_len;
  int m_relock;

  task automatic model_reset();
    lk_pipe.delete();
    for (int i = 0; i < SS; i++) lk_pipe.push_back(1'b0);
    run_len  = 0;
    m_relock = 0;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name);
    logic e_phy, e_mac, e_core, e_done;
    logic [11:0] exp_v, act_v;
    e_phy  = (run_len >= LS + PR);
    e_mac  = !(run_len >= LS + PR + PW);
    e_core = !(run_len >= LS + PR + PW + CD);
    e_done = !e_core;
    exp_v  = {e_phy, e_mac, e_core, e_done, 8'(m_relock)};
    act_v  = {rif.phy_rst_n, rif.mac_rst, rif.core_rst, rif.rst_done, rif.relock_cnt};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s @%0t: got phy_rst_n=%b mac_rst=%b core_rst=%b rst_done=%b relock_cnt=%0d, expected %b %b %b %b %0d",
               name, $time, act_v[11], act_v[10], act_v[9], act_v[8], act_v[7:0],
               e_phy, e_mac, e_core, e_done, m_relock);
    end
  endtask

  // One clock cycle: drive lock, advance the model on the edge, compare on the falling edge.
  task automatic tick(input bit lk);
    bit ls;
    rif.clk_locked = lk;
    @(posedge clk_in);
    ls = lk_pipe.pop_front();
    lk_pipe.push_back(lk);
    if (ls) begin
      run_len++;
    end else begin
      if (run_len >= LS && m_relock < 255) m_relock++;
      run_len = 0;
    end
    @(negedge clk_in);
    check_outputs("cycle");
  endtask

  task automatic run_lock(input int n, output int phy_at, output int mac_at, output int core_at);
    phy_at = -1; mac_at = -1; core_at = -1;
    for (int i = 1; i <= n; i++) begin
      tick(1'b1);
      if (phy_at < 0 && rif.phy_rst_n === 1'b1) phy_at = i;
      if (mac_at < 0 && rif.mac_rst === 1'b0) mac_at = i;
      if (core_at < 0 && rif.core_rst === 1'b0 && rif.rst_done === 1'b1) core_at = i;
    end
  endtask

  task automatic drop_lock(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  int p_at, m_at, c_at;
  int seg_len;
  bit seg_lk;

  initial begin
    rst_in = 1'b1;
    rif.clk_locked = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_outputs("reset_state");
    check_int("reset_relock", int'(rif.relock_cnt), 0);
    rst_in = 1'b0;

    // Clean bring-up with lock high from cycle 0.
    run_lock(50, p_at, m_at, c_at);
    check_int("clean_phy_rise", p_at, 30);
    check_int("clean_mac_fall", m_at, 40);
    check_int("clean_core_fall", c_at, 44);
    check_int("clean_relock", int'(rif.relock_cnt), 0);

    // Lock loss in RUN: everything reasserts three edges after the drop.
    tick(1'b0);
    tick(1'b0);
    check_int("loss_run_early_done", int'(rif.rst_done), 1);
    tick(1'b0);
    check_int("loss_run_phy", int'(rif.phy_rst_n), 0);
    check_int("loss_run_core", int'(rif.core_rst), 1);
    check_int("loss_run_relock", int'(rif.relock_cnt), 1);
    run_lock(50, p_at, m_at, c_at);
    check_int("relock_phy_rise", p_at, 30);
    check_int("relock_core_fall", c_at, 44);

    // Asynchronous reset pulse in RUN, between clock edges.
    #2 rst_in = 1'b1;
    #1;
    check_int("async_rst_phy", int'(rif.phy_rst_n), 0);
    check_int("async_rst_mac", int'(rif.mac_rst), 1);
    check_int("async_rst_done", int'(rif.rst_done), 0);
    check_int("async_rst_relock", int'(rif.relock_cnt), 0);
    model_reset();
    #1 rst_in = 1'b0;

    // Glitchy lock: 5 high, 1 low, then high; the stable count restarts.
    p_at = -1;
    for (int i = 1; i <= 50; i++) begin
      tick(i == 6 ? 1'b0 : 1'b1);
      if (p_at < 0 && rif.phy_rst_n === 1'b1) p_at = i;
    end
    check_int("glitch_phy_rise", p_at, 36);
    check_int("glitch_relock", int'(rif.relock_cnt), 0);

    // Lock loss during PHY_WAIT.
    drop_lock(3);
    run_lock(33, p_at, m_at, c_at);
    check_int("phywait_phy_high", int'(rif.phy_rst_n), 1);
    check_int("phywait_mac_held", int'(rif.mac_rst), 1);
    drop_lock(3);
    check_int("phywait_loss_phy", int'(rif.phy_rst_n), 0);
    check_int("phywait_loss_relock", int'(rif.relock_cnt), 2);
    run_lock(50, p_at, m_at, c_at);
    check_int("phywait_restart_core", c_at, 44);

    // Random lock patterns with run lengths spanning every state boundary.
    for (int s = 0; s < 60; s++) begin
      seg_lk  = ($urandom_range(0, 2) != 0);
      seg_len = seg_lk ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 5));
      for (int i = 0; i < seg_len; i++) tick(seg_lk);
    end

    // Repeated lock loss after reaching RUN saturates the relock counter.
    for (int e = 0; e < 300; e++) begin
      run_lock(45, p_at, m_at, c_at);
      drop_lock(3);
    end
    check_int("sat_relock", int'(rif.relock_cnt), 255);
    check_int("sat_model", m_relock, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
